// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the requester-side handshake and the memory-side
// bus of mem_port_arbiter.
//   Requester side: req, req_we, req_addr, req_wdata (into the arbiter),
//                   ack, grant, rdata, busy (out of the arbiter).
//   Memory side:    mem_en, mem_we, mem_addr, mem_wdata (out of the arbiter),
//                   mem_rdata (into the arbiter).
// Modports: slave = the arbiter, master = the environment (requesters + memory).
interface mem_port_arbiter_if #(
  parameter int NREQ       = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic [NREQ-1:0]            req;
  logic [NREQ-1:0]            req_we;
  logic [NREQ*ADDR_WIDTH-1:0] req_addr;
  logic [NREQ*DATA_WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]            ack;
  logic [NREQ-1:0]            grant;
  logic [DATA_WIDTH-1:0]      rdata;
  logic                       busy;
  logic                       mem_en;
  logic                       mem_we;
  logic [ADDR_WIDTH-1:0]      mem_addr;
  logic [DATA_WIDTH-1:0]      mem_wdata;
  logic [DATA_WIDTH-1:0]      mem_rdata;

  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_rdata,
    output ack, grant, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, req_we, req_addr, req_wdata, mem_rdata,
    input  ack, grant, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter and sequencer sharing one single-ported,
// fixed-latency memory between NREQ requesters.
// Each transaction: IDLE (arbitrate + latch) -> ISSUE (one-cycle mem_en) ->
// WAIT (LATENCY cycles, read data captured in the last one) -> ACK (one-cycle
// ack to the owner) -> IDLE.
// Ports:
//   clk   - clock, everything on the rising edge
//   reset - synchronous, active-high; aborts any transaction in flight
//   bus   - mem_port_arbiter_if.slave: requester handshake and memory bus
module mem_port_arbiter #(
  parameter int NREQ       = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0]       WAIT_LOAD  = 4'(LATENCY - 1);
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NREQ - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_port_arbiter: LATENCY=%0d outside 1..15", LATENCY);
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("mem_port_arbiter: NREQ=%0d outside 2..8", NREQ);
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ACK
  } state_t;

  state_t           state;
  logic [3:0]       wait_cnt;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] last;

  // Per-requester views of the flattened address/data buses.
  logic [ADDR_WIDTH-1:0] addr_arr  [NREQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = bus.req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: first requester at or after last+1, wrapping.
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves it unassigned and no latch is inferred.
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(last) + k) % NREQ);
      if (!pick_valid && bus.req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Single-process FSM; every bus output is a register, updated on the edge
  // that enters the state in which it must be visible.
  // NOTE: sequential state uses non-blocking assignments only, so all
  // registers update together from pre-edge values regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      owner         <= '0;
      last          <= LAST_RESET;
      bus.ack       <= '0;
      bus.grant     <= '0;
      bus.busy      <= 1'b0;
      bus.rdata     <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            // The memory bus registers double as the latched request; they
            // hold untouched until the next win, so later req changes are
            // invisible to the transaction in flight.
            owner         <= pick_idx;
            bus.grant     <= NREQ'(1) << pick_idx;
            bus.busy      <= 1'b1;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= bus.req_we[pick_idx];
            bus.mem_addr  <= addr_arr[pick_idx];
            bus.mem_wdata <= wdata_arr[pick_idx];
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          bus.mem_en <= 1'b0;
          wait_cnt   <= WAIT_LOAD;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            // Last wait cycle: memory read data is valid now.
            if (!bus.mem_we) begin
              bus.rdata <= bus.mem_rdata;
            end
            bus.ack <= bus.grant;
            state   <= ST_ACK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ACK: begin
          bus.ack   <= '0;
          bus.grant <= '0;
          bus.busy  <= 1'b0;
          last      <= owner;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vector table, hand-written corner
// sequences and a random run, all compared every cycle against a
// transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif ();
  mem_port_arbiter_if #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) xif1 ();
  mem_port_arbiter_if #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) xif15 ();

  mem_port_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .bus(mif)
  );
  mem_port_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(xif1)
  );
  mem_port_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(15)) dut15 (
    .clk(clk), .reset(reset), .bus(xif15)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Requester-side drive values for the main DUT, applied by cycle().
  logic [NREQ-1:0] d_req   = '0;
  logic [NREQ-1:0] d_we    = '0;
  logic [AW-1:0]   d_addr  [NREQ];
  logic [DW-1:0]   d_wdata [NREQ];
  logic            d_reset = 1'b1;
  logic [NREQ-1:0] prev_ack = '0;

  // Drive values for the LATENCY=1 / LATENCY=15 instances (requester 0 only).
  logic            x_req  = 1'b0;
  logic [DW-1:0]   x_rd1  = '0;
  logic [DW-1:0]   x_rd15 = '0;

  // Behavioural memory for the main DUT.
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            rd_cycle = -1;
  logic [DW-1:0] rd_val   = '0;

  // Transaction-level model: one record for the transaction won at cycle m_w.
  int            m_w     = -1000;
  int            m_free  = 0;
  int            m_owner = 0;
  int            m_last  = NREQ - 1;
  logic          m_we    = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  bit            m_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    oh = NREQ'(1) << i;
  endfunction

  function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]} ^ 32'h3C3C_0000;
  endfunction

  // Memory: writes land on the strobe; read data is presented only in the
  // single cycle LAT after the strobe, garbage otherwise.
  always @(negedge clk) begin
    if (mif.mem_en === 1'b1) begin
      if (mif.mem_we) mem[mif.mem_addr] = mif.mem_wdata;
      else begin
        rd_cycle = cyc + LAT;
        rd_val   = memval(mif.mem_addr);
      end
    end
    mif.mem_rdata = (cyc == rd_cycle) ? rd_val : (rd_val ^ 32'hFFFF_0000 ^ DW'(cyc));
  end

  // One clock cycle: drive inputs after the edge, run the model, compare at
  // the falling edge.
  task automatic cycle();
    logic [NREQ-1:0] e_ack, e_grant;
    logic            e_busy, e_en, e_hold;
    logic [DW-1:0]   e_rdata;
    int              win;
    @(posedge clk);
    cyc++;
    #1;
    reset         = d_reset;
    mif.req       = d_req;
    mif.req_we    = d_we;
    mif.req_addr  = {d_addr[3], d_addr[2], d_addr[1], d_addr[0]};
    mif.req_wdata = {d_wdata[3], d_wdata[2], d_wdata[1], d_wdata[0]};
    xif1.req       = {3'b000, x_req};
    xif15.req      = {3'b000, x_req};
    xif1.mem_rdata  = x_rd1;
    xif15.mem_rdata = x_rd15;

    // Owner is visible from the strobe cycle through the ack cycle.
    e_busy  = (cyc >= m_w + 1) && (cyc <= m_w + 2 + LAT);
    e_grant = e_busy ? oh(m_owner) : '0;
    e_en    = (cyc == m_w + 1);
    e_hold  = (cyc >= m_w + 1) && (cyc <= m_w + 1 + LAT);
    e_ack   = (cyc == m_w + 2 + LAT) ? oh(m_owner) : '0;
    if (cyc == m_w + 2 + LAT && !m_we) m_rdata = memval(m_addr);
    e_rdata = m_rdata;

    if (d_reset) begin
      m_w     = -1000;
      m_free  = cyc + 1;
      m_last  = NREQ - 1;
      m_rdata = '0;
    end else if (cyc >= m_free && d_req != '0) begin
      win = 0;
      for (int k = 1; k <= NREQ; k++) begin
        if (d_req[(m_last + k) % NREQ]) begin
          win = (m_last + k) % NREQ;
          break;
        end
      end
      m_w     = cyc;
      m_owner = win;
      m_we    = d_we[win];
      m_addr  = d_addr[win];
      m_wdata = d_wdata[win];
      m_free  = cyc + 3 + LAT;
      m_last  = win;
    end

    @(negedge clk);
    if (m_valid) begin
      check("ack",    64'(mif.ack),    64'(e_ack));
      check("grant",  64'(mif.grant),  64'(e_grant));
      check("busy",   64'(mif.busy),   64'(e_busy));
      check("mem_en", 64'(mif.mem_en), 64'(e_en));
      check("rdata",  64'(mif.rdata),  64'(e_rdata));
      check("ack_onehot",   64'($onehot0(mif.ack)),        64'(1));
      check("grant_onehot", 64'($onehot0(mif.grant)),      64'(1));
      check("ack_in_grant", 64'(|(mif.ack & ~mif.grant)), 64'(0));
      if (e_hold) begin
        check("mem_we",   64'(mif.mem_we),   64'(m_we));
        check("mem_addr", 64'(mif.mem_addr), 64'(m_addr));
        if (m_we) check("mem_wdata", 64'(mif.mem_wdata), 64'(m_wdata));
      end
    end
    if (d_reset) m_valid = 1'b1;
    prev_ack = mif.ack;
  endtask

  typedef struct {
    int          idx;
    logic        we;
    logic        pl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] preload;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt [6];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int order[$];
    int ack_cyc[$];
    int c0, a1, a15, amain;
    logic [DW-1:0] r1, r15;
    logic any_ack;

    for (int i = 0; i < NREQ; i++) begin
      d_addr[i]  = '0;
      d_wdata[i] = '0;
    end
    xif1.req_we = '0;  xif1.req_addr = {96'd0, 32'h100};  xif1.req_wdata = '0;
    xif15.req_we = '0; xif15.req_addr = {96'd0, 32'h100}; xif15.req_wdata = '0;

    // ---------------- reset state
    d_reset = 1'b1;
    cycle();
    cycle();
    check("rst_busy",     64'(mif.busy),     64'(0));
    check("rst_ack",      64'(mif.ack),      64'(0));
    check("rst_grant",    64'(mif.grant),    64'(0));
    check("rst_mem_en",   64'(mif.mem_en),   64'(0));
    check("rst_rdata",    64'(mif.rdata),    64'(0));
    check("rst_mem_addr", 64'(mif.mem_addr), 64'(0));
    d_reset = 1'b0;

    // ---------------- single-transaction vector table
    vt[0] = '{0, 1'b0, 1'b1, 32'h0000_0100, 32'h0,          32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vt[1] = '{3, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0,          32'h0000_0001, 32'h0000_0001};
    vt[2] = '{2, 1'b0, 1'b1, 32'h0000_0000, 32'h0,          32'h0000_00A5, 32'h0000_00A5};
    vt[3] = '{2, 1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678, 32'h0,          32'h0000_00A5};
    vt[4] = '{1, 1'b0, 1'b0, 32'h0000_0040, 32'h0,          32'h0,          32'h1234_5678};
    vt[5] = '{0, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,          32'h1234_5678};

    for (int v = 0; v < 6; v++) begin
      if (vt[v].pl) mem[vt[v].addr] = vt[v].preload;
      d_req              = oh(vt[v].idx);
      d_we               = '0;
      d_we[vt[v].idx]    = vt[v].we;
      d_addr[vt[v].idx]  = vt[v].addr;
      d_wdata[vt[v].idx] = vt[v].wdata;
      for (int rel = 0; rel <= LAT + 3; rel++) begin
        if (rel == LAT + 3) d_req = '0;
        cycle();
        check("vec_busy", 64'(mif.busy), 64'(rel >= 1 && rel <= LAT + 2));
        if (rel == 1) begin
          check("vec_mem_en",   64'(mif.mem_en),   64'(1));
          check("vec_mem_addr", 64'(mif.mem_addr), 64'(vt[v].addr));
          check("vec_mem_we",   64'(mif.mem_we),   64'(vt[v].we));
          if (vt[v].we) check("vec_mem_wdata", 64'(mif.mem_wdata), 64'(vt[v].wdata));
        end
        if (rel == LAT + 2) begin
          check("vec_ack",   64'(mif.ack),   64'(oh(vt[v].idx)));
          check("vec_rdata", 64'(mif.rdata), 64'(vt[v].exp_rdata));
        end
      end
    end
    d_we = '0;

    // ---------------- all four requesting from reset release
    for (int i = 0; i < NREQ; i++) d_addr[i] = 32'h1000 + 32'(i * 4);
    d_reset = 1'b1;
    cycle();
    d_reset = 1'b0;
    d_req   = 4'hF;
    c0      = cyc + 1;
    for (int n = 0; n < 60 && order.size() < 4; n++) begin
      cycle();
      for (int i = 0; i < NREQ; i++) begin
        if (mif.ack[i]) begin
          order.push_back(i);
          ack_cyc.push_back(cyc);
        end
      end
      d_req = d_req & ~mif.ack;
    end
    check("all4_count", 64'(order.size()), 64'(4));
    for (int k = 0; k < order.size(); k++) check("all4_order", 64'(order[k]), 64'(k));
    if (ack_cyc.size() > 0) check("all4_first_ack", 64'(ack_cyc[0] - c0), 64'(LAT + 2));
    for (int k = 1; k < ack_cyc.size(); k++)
      check("all4_spacing", 64'(ack_cyc[k] - ack_cyc[k-1]), 64'(LAT + 3));
    d_req = '0;

    // ---------------- fairness: requesters 1 and 3 held high
    order.delete();
    d_req = 4'b1010;
    for (int n = 0; n < 80 && order.size() < 6; n++) begin
      cycle();
      for (int i = 0; i < NREQ; i++) if (mif.ack[i]) order.push_back(i);
    end
    d_req = '0;
    cycle();
    check("fair_count", 64'(order.size()), 64'(6));
    for (int k = 0; k < order.size(); k++)
      check("fair_order", 64'(order[k]), 64'((k % 2 == 0) ? 1 : 3));

    // ---------------- reset in the second WAIT cycle
    d_addr[0] = 32'h0000_0080;
    d_req     = 4'b0001;
    for (int rel = 0; rel <= LAT + 3; rel++) begin
      if (rel == LAT + 3) d_req = '0;
      cycle();
    end
    d_addr[0] = 32'h0000_0200;
    d_addr[3] = 32'h0000_0300;
    d_req     = 4'b0001;
    any_ack   = 1'b0;
    for (int rel = 0; rel <= 3; rel++) begin
      if (rel == 3) d_reset = 1'b1;
      cycle();
      any_ack = any_ack | (|mif.ack);
    end
    d_reset = 1'b0;
    d_req   = 4'b1001;
    cycle();
    any_ack = any_ack | (|mif.ack);
    check("rst_mid_no_ack", 64'(any_ack),    64'(0));
    check("rst_mid_busy",   64'(mif.busy),   64'(0));
    check("rst_mid_grant",  64'(mif.grant),  64'(0));
    check("rst_mid_mem_en", 64'(mif.mem_en), 64'(0));
    cycle();
    check("rst_mid_winner", 64'(mif.grant), 64'(4'b0001));
    for (int n = 0; n < 40 && (d_req != '0 || mif.busy); n++) begin
      cycle();
      d_req = d_req & ~mif.ack;
    end
    check("rst_mid_drained", 64'(d_req), 64'(0));

    // ---------------- req dropped in WAIT; LATENCY 1 and 15 instances
    mem[32'h0000_0300] = 32'hCAFE_F00D;
    d_addr[1] = 32'h0000_0300;
    d_we      = '0;
    d_req     = 4'b0010;
    x_req     = 1'b1;
    a1 = -1; a15 = -1; amain = -1; r1 = '0; r15 = '0;
    for (int rel = 0; rel <= 19; rel++) begin
      if (rel == 2) begin
        d_req = '0;
        x_req = 1'b0;
      end
      x_rd1  = (rel == 2)  ? 32'h1111_0001 : 32'h0BAD_0001;
      x_rd15 = (rel == 16) ? 32'h1515_0015 : 32'h0BAD_0015;
      cycle();
      if (mif.ack != '0 && amain < 0) begin
        amain = rel;
        check("drop_ack_vec", 64'(mif.ack),   64'(4'b0010));
        check("drop_rdata",   64'(mif.rdata), 64'(32'hCAFE_F00D));
      end
      if (xif1.ack[0] && a1 < 0) begin
        a1 = rel;
        r1 = xif1.rdata;
      end
      if (xif15.ack[0] && a15 < 0) begin
        a15 = rel;
        r15 = xif15.rdata;
      end
    end
    x_rd1  = '0;
    x_rd15 = '0;
    check("drop_ack_cycle", 64'(amain), 64'(4));
    check("lat1_ack_cycle", 64'(a1),    64'(3));
    check("lat1_rdata",     64'(r1),    64'(32'h1111_0001));
    check("lat15_ack_cycle", 64'(a15),  64'(17));
    check("lat15_rdata",    64'(r15),   64'(32'h1515_0015));

    // ---------------- random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (prev_ack[i]) begin
          if ($urandom_range(3) != 0) d_req[i] = 1'b0;
          d_we[i]    = 1'($urandom_range(1));
          d_addr[i]  = 32'($urandom_range(31)) << 2;
          d_wdata[i] = $urandom;
        end else if (!d_req[i] && $urandom_range(5) == 0) begin
          d_req[i]   = 1'b1;
          d_we[i]    = 1'($urandom_range(1));
          d_addr[i]  = 32'($urandom_range(31)) << 2;
          d_wdata[i] = $urandom;
        end else if (d_req[i] && mif.grant[i] && $urandom_range(7) == 0) begin
          d_addr[i]  = $urandom;
          d_wdata[i] = $urandom;
          d_we[i]    = ~d_we[i];
          if ($urandom_range(1) == 0) d_req[i] = 1'b0;
        end
      end
      d_reset = ($urandom_range(499) == 0);
      cycle();
    end
    d_reset = 1'b0;
    d_req   = '0;
    for (int n = 0; n < 12; n++) cycle();
    check("end_idle", 64'(mif.busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
